// File: rtl/ser_pkg.sv
// Shared definitions for the parallel-to-serial transmitter: state
// encoding, default word width and the counter-width helper.
package ser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t GAP   = 2'd2;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Modulo-N up-counter with synchronous clear, count enable and a
// terminal-count flag that is high while the count sits at N-1.
module ser_bit_counter
    import ser_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count;

    // Count register: clear wins over enable, wraps to zero after N-1.
    // NOTE: clocked state is written with <= so every register samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter feeding an LSB-first serial receiver.
// A word accepted through the load handshake is shifted out one bit per
// clock with frame high, followed by a programmable idle gap.
module parallel_to_serial
    import ser_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             frame,
    output logic             done,
    output logic             busy
);

    // A zero-cycle gap still instantiates a legal (unused) gap counter.
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam int GAP_N   = HAS_GAP ? GAP_CYCLES : 1;

    state_t           state;
    state_t           state_nxt;
    logic             fire;
    logic             bit_clr;
    logic             bit_en;
    logic             bit_tc;
    logic             gap_clr;
    logic             gap_en;
    logic             gap_tc;
    logic [WIDTH-1:0] shreg;

    // Counts the bit positions of the frame in flight.
    ser_bit_counter #(.N(WIDTH)) u_bit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bit_clr),
        .enable (bit_en),
        .tc     (bit_tc)
    );

    // Counts idle cycles after a frame.
    ser_bit_counter #(.N(GAP_N)) u_gap_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (gap_clr),
        .enable (gap_en),
        .tc     (gap_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: load in IDLE, leave SHIFT on the last bit, leave GAP on the last idle cycle.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire)   state_nxt = SHIFT;
            SHIFT:   if (bit_tc) state_nxt = HAS_GAP ? GAP : IDLE;
            GAP:     if (gap_tc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: handshake ready and counter controls derived from state.
    always_comb begin
        load_ready = (state == IDLE);
        fire       = load_valid && load_ready;
        bit_clr    = fire;
        bit_en     = (state == SHIFT);
        gap_clr    = (state == SHIFT) && bit_tc;
        gap_en     = (state == GAP);
    end

    // Registered datapath: captures the word, rotates it and drives the serial outputs.
    // NOTE: the shift register is a handful of flops, not a memory, so it is
    // reset with the rest of the state and never carries X onto ser_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            ser_out <= 1'b0;
            frame   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        shreg   <= data_in;
                        ser_out <= data_in[0];
                        frame   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Rotate rather than shift so bit 0 stays in use; contents after the frame are don't-care.
                    shreg <= {shreg[0], shreg[WIDTH-1:1]};
                    if (bit_tc) begin
                        frame   <= 1'b0;
                        ser_out <= 1'b0;
                        done    <= 1'b1;
                        busy    <= HAS_GAP;
                    end else begin
                        ser_out <= shreg[1];
                    end
                end
                GAP: begin
                    if (gap_tc) busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: an 8-bit / one-gap instance checked with a
// receiver-side scoreboard, plus a 4-bit / zero-gap instance for framing.
module tb_parallel_to_serial;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       load_valid = 1'b0;
    logic       load_ready, ser_out, frame, done, busy;

    logic [3:0] d4_data = '0;
    logic       d4_valid = 1'b0;
    logic       d4_ready, d4_ser, d4_frame, d4_done, d4_busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         acc_q[$];
    logic [7:0] rx = '0;
    logic [7:0] exp_word;
    int         rx_bits = 0;
    int         frames_rx = 0;
    int         done_cnt = 0;

    parallel_to_serial #(.WIDTH(8), .GAP_CYCLES(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .frame      (frame),
        .done       (done),
        .busy       (busy)
    );

    parallel_to_serial #(.WIDTH(4), .GAP_CYCLES(0)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (d4_data),
        .load_valid (d4_valid),
        .load_ready (d4_ready),
        .ser_out    (d4_ser),
        .frame      (d4_frame),
        .done       (d4_done),
        .busy       (d4_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Receiver model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            rx_bits = 0;
        end else begin
            if (load_valid && load_ready) begin
                exp_q.push_back(data_in);
                acc_q.push_back(cyc + 1);
            end
            if (frame) begin
                rx = {ser_out, rx[7:1]};
                rx_bits++;
            end
            if (done) begin
                done_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_unexpected: received %h after %0d bits, required no frame", rx, rx_bits);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (rx !== exp_word || rx_bits != W) begin
                        miscompares++;
                        $display("FAIL rx_word: received %h in %0d frame cycles, required %h in %0d",
                                 rx, rx_bits, exp_word, W);
                    end
                end
                frames_rx++;
                rx_bits = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!load_ready) begin
            miscompares++;
            $display("FAIL idle_timeout: load_ready=%b, required 1", load_ready);
        end
    endtask

    // Present a word and hold it until the accepting edge; returns just after that edge.
    task automatic send(input logic [7:0] w);
        @(posedge clk); #1;
        data_in    = w;
        load_valid = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_rx < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (frames_rx < target) begin
            miscompares++;
            $display("FAIL frame_timeout: frames=%0d, required %0d", frames_rx, target);
        end
    endtask

    task automatic test_reset();
        load_valid = 1'b1;
        data_in    = 8'h55;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ser_out, frame, done, busy, load_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_outputs: ser/frame/done/busy/ready=%b, required 00001",
                     {ser_out, frame, done, busy, load_ready});
        end
        vectors++;
        if ({d4_ser, d4_frame, d4_done, d4_busy, d4_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_outputs_w4: ser/frame/done/busy/ready=%b, required 00001",
                     {d4_ser, d4_frame, d4_done, d4_busy, d4_ready});
        end
        data_in = 8'h83;
    endtask

    // load_valid already high at release: the word goes at the first edge.
    task automatic test_first_frame();
        logic [7:0] w = 8'h83;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            vectors++;
            if (frame !== 1'b1 || ser_out !== w[i] || done !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL first_bit%0d: frame=%b ser=%b done=%b busy=%b, required 1 %b 0 1",
                         i, frame, ser_out, done, busy, w[i]);
            end
        end
        @(negedge clk);
        vectors++;
        if (frame !== 1'b0 || done !== 1'b1 || ser_out !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_done: frame=%b done=%b ser=%b busy=%b, required 0 1 0 1",
                     frame, done, ser_out, busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL first_after_gap: done=%b ready=%b busy=%b, required 0 1 0",
                     done, load_ready, busy);
        end
        wait_frames(1);
    endtask

    task automatic test_back_to_back();
        int low = 0;
        int f0 = frames_rx;
        int a0, a1;
        wait_idle();
        @(posedge clk); #1;
        data_in    = 8'hA5;
        load_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 8'h3C;
        @(negedge clk);
        while (!load_ready && low < 40) begin
            low++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        vectors++;
        if (low != 9) begin
            miscompares++;
            $display("FAIL b2b_ready_low: load_ready low for %0d cycles, required 9", low);
        end
        a1 = acc_q[acc_q.size() - 1];
        a0 = acc_q[acc_q.size() - 2];
        vectors++;
        if (a1 - a0 != 10) begin
            miscompares++;
            $display("FAIL b2b_spacing: acceptances %0d cycles apart, required 10", a1 - a0);
        end
        wait_frames(f0 + 2);
    endtask

    task automatic test_ignore_during_shift();
        int f0 = frames_rx;
        send(8'h00);
        @(posedge clk); #1;
        data_in    = 8'hFF;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (30) @(negedge clk);
        vectors++;
        if (frames_rx != f0 + 1) begin
            miscompares++;
            $display("FAIL ignore_frames: %0d frames sent, required 1", frames_rx - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int f0 = frames_rx;
        int d0 = done_cnt;
        send(8'h5A);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({frame, ser_out, busy, load_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL midreset_outputs: frame/ser/busy/ready=%b, required 0001",
                     {frame, ser_out, busy, load_ready});
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        vectors++;
        if (done_cnt != d0 || frames_rx != f0 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_discard: done pulses=%0d ready=%b, required 0 and 1",
                     done_cnt - d0, load_ready);
        end
        send(8'h81);
        wait_frames(f0 + 1);
    endtask

    task automatic test_data_change();
        int f0 = frames_rx;
        send(8'hC3);
        data_in = 8'h00;
        wait_frames(f0 + 1);
    endtask

    task automatic test_gap0_width4();
        logic [9:0] exp_frame = 10'b0111101111;
        logic [9:0] exp_ser   = 10'b0011001001;
        d4_valid = 1'b0;
        @(posedge clk); #1;
        d4_data  = 4'h9;
        d4_valid = 1'b1;
        @(posedge clk); #1;
        d4_data = 4'h6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (d4_frame !== exp_frame[i] || d4_ser !== exp_ser[i]) begin
                miscompares++;
                $display("FAIL w4_cycle%0d: frame=%b ser=%b, required %b %b",
                         i, d4_frame, d4_ser, exp_frame[i], exp_ser[i]);
            end
            if (i == 4) begin
                vectors++;
                if (d4_done !== 1'b1 || d4_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL w4_done: done=%b ready=%b, required 1 1", d4_done, d4_ready);
                end
                @(posedge clk); #1;
                d4_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_ignore_during_shift();
        test_reset_mid_frame();
        test_data_change();
        test_gap0_width4();
        repeat (5) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_words: %0d words never received, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Upstream feeder for the 8-bit serial_to_parallel receiver.
- Accepts a parallel word through a valid/ready load handshake and shifts it out LSB-first, one bit per clk.
- Drives `frame`, which connects directly to the receiver's `start` input, so that after WIDTH frame cycles the receiver's `out_p` equals the loaded word.
- Inserts a programmable idle gap between frames so the receiver can be cleared.

Parameters:
- WIDTH, 8, word width in bits; must be ≥ 2.
- GAP_CYCLES, 1, idle cycles with frame low after each word; range 0..15.

Ports:
- clk  in  1  rising-edge system clock
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  WIDTH  parallel word to transmit
- load_valid  in  1  source has a word on data_in
- load_ready  out  1  block can accept a word; high only in IDLE
- ser_out  out  1  serial data, LSB first; connects to receiver `a`
- frame  out  1  high while ser_out carries valid bits; connects to receiver `start`
- done  out  1  one-cycle pulse when the last bit has been presented
- busy  out  1  high in SHIFT or GAP

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shreg = 0; bit counter = 0; gap counter = 0.
  - ser_out = 0, frame = 0, done = 0, busy = 0, load_ready = 1.
  - load_valid is ignored while rst_n is low.
- All outputs except load_ready are registered. load_ready = (state == IDLE), decoded combinationally from state.
- States and transitions:
  - IDLE: on an edge with load_valid & load_ready → SHIFT. Same edge: shreg ← data_in, ser_out ← data_in[0], frame ← 1, busy ← 1, bit counter ← 0.
  - SHIFT: each edge shifts shreg right and sets ser_out ← next bit, bit counter +1. At the edge where bit counter == WIDTH-1:
    - frame ← 0, ser_out ← 0, done ← 1 for one cycle.
    - → GAP (gap counter ← 0) if GAP_CYCLES > 0, else → IDLE with busy ← 0.
  - GAP: frame stays 0; gap counter +1 per edge. At gap counter == GAP_CYCLES-1 → IDLE, busy ← 0.
- Timing:
  - Load accepted at edge E0. ser_out carries bit i during the cycle after edge Ei, for i = 0..WIDTH-1.
  - frame is high for exactly WIDTH cycles.
  - The receiver samples bit i at edge E(i+1).
  - Load-to-done latency: done rises at edge E_WIDTH.
  - Minimum load-to-load spacing: WIDTH + GAP_CYCLES + 1 cycles.
- Handshake:
  - Transfer occurs only on an edge with both load_valid and load_ready high.
  - The source must hold data_in stable until the transfer.
  - load_valid in SHIFT or GAP is ignored and not queued.
  - data_in changes after acceptance do not affect the frame in flight.
- Boundaries:
  - All-zero or all-one words are transmitted unchanged.
  - With GAP_CYCLES = 0, the earliest next acceptance is the first IDLE cycle, so frame drops for at least one cycle between words.
  - rst_n asserted mid-frame: frame and ser_out drop immediately, done does not pulse, and the partial word is discarded.
  - load_valid high during the first cycle after reset release: accepted at the next edge.

Decomposition:
- Shared package ser_pkg holds:
  - state encoding localparams: IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2;
  - the WIDTH default (8);
  - the counter width function (clog2).
- One natural sub-module: ser_bit_counter, a modulo-N up-counter with clear, enable and terminal-count output. It is instantiated twice, once for bits and once for gap cycles.

Test Plan:
1. Reset, then load 0x83 with GAP_CYCLES = 1 → ser_out sequence 1,1,0,0,0,0,0,1 with frame high for 8 cycles, done pulses at edge 8, and the chained serial_to_parallel out_p = 0x83.
2. Hold load_valid high with words 0xA5 then 0x3C back-to-back → second acceptance occurs exactly WIDTH + GAP_CYCLES + 1 = 10 cycles after the first, load_ready is low in between, and both words are received intact.
3. Pulse load_valid with 0xFF during SHIFT of 0x00 → the pulse is ignored, the receiver gets 0x00, and no second frame is sent.
4. Assert rst_n low at bit 4 of 0x5A → frame and ser_out go to 0 immediately, no done pulse, and after release load_ready = 1 and the next word 0x81 transmits correctly.
5. Run with GAP_CYCLES = 0 and WIDTH = 4, loading 0x9 then 0x6 → bits 1,0,0,1 then 0,1,1,0, with frame low for exactly 1 cycle between frames.
6. Change data_in from 0xC3 to 0x00 one cycle after acceptance of 0xC3 → the transmitted word is still 0xC3.
